// File: rtl/fig8_drive_sequencer_pkg.sv
// Shared encodings for the figure-8 drive sequencer: FSM states, segment codes
// and the wheel-velocity width used on the command path.
package fig8_pkg;

    localparam int VEL_W = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEND = 3'd1,
        RUN  = 3'd2,
        STOP = 3'd3,
        DONE = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        SEG_STR_A = 2'd0,
        SEG_ARC_L = 2'd1,
        SEG_STR_B = 2'd2,
        SEG_ARC_R = 2'd3
    } seg_e;

    function automatic logic seg_is_arc(input seg_e s);
        return (s == SEG_ARC_L) || (s == SEG_ARC_R);
    endfunction

endpackage

// File: rtl/fig8_drive_sequencer_tick_prescaler.sv
// Segment timebase: one-cycle tick every TICK_DIV clocks while enabled.
// clr restarts the count so every segment begins on a full tick period.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [31:0] CNT_LAST = 32'(TICK_DIV - 1);

    logic [31:0] cnt;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 32'd1;
            end
        end
    end

    assign tick = en && !clr && (cnt == CNT_LAST);

endmodule

// File: rtl/fig8_drive_sequencer.sv
// Figure-8 manoeuvre sequencer: steps STRAIGHT, ARC_LEFT, STRAIGHT, ARC_RIGHT per
// lap and issues one wheel-velocity command per segment over valid/ready.
module fig8_drive_sequencer
    import fig8_pkg::*;
#(
    parameter int TICK_DIV   = 50_000,
    parameter int T_STRAIGHT = 2000,
    parameter int T_ARC      = 3000,
    parameter int V_FWD      = 200,
    parameter int V_IN       = 100,
    parameter int V_OUT      = 300,
    parameter int LAPS       = 1
) (
    input  logic                    clk_in,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    cmd_ready,
    output logic                    cmd_valid,
    output logic signed [VEL_W-1:0] cmd_left,
    output logic signed [VEL_W-1:0] cmd_right,
    output logic                    busy,
    output logic                    done,
    output logic [7:0]              lap_count,
    output logic [2:0]              state_o
);

    localparam logic [VEL_W-1:0] VEL_FWD_W = VEL_W'(V_FWD);
    localparam logic [VEL_W-1:0] VEL_IN_W  = VEL_W'(V_IN);
    localparam logic [VEL_W-1:0] VEL_OUT_W = VEL_W'(V_OUT);
    localparam logic [31:0]      STR_LAST  = 32'(T_STRAIGHT - 1);
    localparam logic [31:0]      ARC_LAST  = 32'(T_ARC - 1);
    localparam logic [7:0]       LAPS_W    = 8'(LAPS);

    state_e state, state_next;
    seg_e   seg, seg_next;
    logic [7:0] lap_next;
    logic [7:0] lap_inc;
    logic signed [VEL_W-1:0] cmd_left_next, cmd_right_next;
    logic abort_seen, abort_seen_next;
    logic [31:0] seg_cnt;
    logic [31:0] dur_last;
    logic tick;
    logic seg_end;
    logic handshake;

    // Arc segments drive the outer wheel faster; the side flips between left and right arcs.
    function automatic logic [2*VEL_W-1:0] seg_velocity(input seg_e s);
        case (s)
            SEG_ARC_L: return {VEL_IN_W, VEL_OUT_W};
            SEG_ARC_R: return {VEL_OUT_W, VEL_IN_W};
            default:   return {VEL_FWD_W, VEL_FWD_W};
        endcase
    endfunction

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk_in(clk_in),
        .rst_n (rst_n),
        .en    (state == RUN),
        .clr   (state != RUN),
        .tick  (tick)
    );

    assign handshake = cmd_valid && cmd_ready;
    assign dur_last  = seg_is_arc(seg) ? ARC_LAST : STR_LAST;
    assign seg_end   = tick && (seg_cnt == dur_last);
    assign lap_inc   = lap_count + 8'd1;

    always_comb begin
        state_next      = state;
        seg_next        = seg;
        lap_next        = lap_count;
        cmd_left_next   = cmd_left;
        cmd_right_next  = cmd_right;
        abort_seen_next = (state == SEND) && (abort_seen || abort);

        case (state)
            IDLE, DONE: begin
                if (start && !abort) begin
                    lap_next   = 8'd0;
                    seg_next   = SEG_STR_A;
                    {cmd_left_next, cmd_right_next} = seg_velocity(SEG_STR_A);
                    state_next = SEND;
                end
            end
            SEND: begin
                // An abort seen during the transfer only takes effect once the command is accepted.
                if (handshake) begin
                    if (abort_seen || abort) begin
                        cmd_left_next  = '0;
                        cmd_right_next = '0;
                        state_next     = STOP;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    cmd_left_next  = '0;
                    cmd_right_next = '0;
                    state_next     = STOP;
                end else if (seg_end) begin
                    if (seg != SEG_ARC_R) begin
                        seg_next   = seg_e'(seg + 2'd1);
                        {cmd_left_next, cmd_right_next} = seg_velocity(seg_e'(seg + 2'd1));
                        state_next = SEND;
                    end else begin
                        lap_next = lap_inc;
                        if (lap_inc == LAPS_W) begin
                            cmd_left_next  = '0;
                            cmd_right_next = '0;
                            state_next     = STOP;
                        end else begin
                            seg_next   = SEG_STR_A;
                            {cmd_left_next, cmd_right_next} = seg_velocity(SEG_STR_A);
                            state_next = SEND;
                        end
                    end
                end
            end
            STOP: begin
                if (handshake) begin
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            seg        <= SEG_STR_A;
            lap_count  <= 8'd0;
            cmd_left   <= '0;
            cmd_right  <= '0;
            abort_seen <= 1'b0;
        end else begin
            state      <= state_next;
            seg        <= seg_next;
            lap_count  <= lap_next;
            cmd_left   <= cmd_left_next;
            cmd_right  <= cmd_right_next;
            abort_seen <= abort_seen_next;
        end
    end

    // Counts completed ticks within the current segment; restarts whenever RUN is left.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            seg_cnt <= 32'd0;
        end else if (state != RUN) begin
            seg_cnt <= 32'd0;
        end else if (tick) begin
            seg_cnt <= seg_cnt + 32'd1;
        end
    end

    assign cmd_valid = (state == SEND) || (state == STOP);
    assign busy      = (state == SEND) || (state == RUN) || (state == STOP);
    assign done      = (state == DONE);
    assign state_o   = state;

endmodule
